// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: divides clk_i to a per-digit dwell
// and rotates selec_o/anodo_o through the enabled digits. Optional GHOST_BLANK_EN.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [3:0] digit_en_i,
  output logic [1:0] selec_o,
  output logic [3:0] anodo_o,
  output logic       tick_o
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          strobe;
  logic [1:0]    next_sel;
  logic [1:0]    idx;
  logic          found;
  logic          blanking;
  logic [3:0]    onehot;

  assign strobe = en_i && (prescaler == TERM);

  // Search offsets +1,+2,+3,+0 so the current digit is the last resort.
  always_comb begin
    next_sel = selec_o;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = selec_o + 2'(i);
      if (!found && digit_en_i[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prescaler <= '0;
      selec_o   <= '0;
      tick_o    <= 1'b0;
    end else begin
      tick_o <= strobe;
      if (en_i) begin
        prescaler <= strobe ? '0 : prescaler + 1'b1;
      end
      if (strobe) begin
        selec_o <= next_sel;
      end
    end
  end

`ifdef GHOST_BLANK_EN
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);
  assign blanking = (prescaler < BLANK);
`else
  assign blanking = 1'b0;
`endif

  assign onehot = 4'b0001 << selec_o;

  // Reset also darkens the anodes so the display is off while held in reset.
  always_comb begin
    anodo_o = '1;
    if (rst_n_i && en_i && !blanking) begin
      anodo_o = ~(onehot & digit_en_i);
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexing controller for the 4-digit seven-segment display.
- Sits directly upstream of the 4:1 digit mux: drives the mux select (selec) and the matching active-low digit anode enables.
- Divides the system clock to a per-digit dwell period and rotates through enabled digits, skipping masked-off ones.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit dwell (100 MHz → 1 kHz per digit); legal range ≥ 2.
- BLANK_CYCLES, 64, anode-off cycles at the start of each dwell; used only when GHOST_BLANK_EN is defined; must be < REFRESH_DIV.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- en_i  input  1  scan enable; low = freeze scan, display dark.
- digit_en_i  input  4  per-digit enable mask, bit n = digit n.
- selec_o  output  2  digit index to the mux select input.
- anodo_o  output  4  active-low anode enables, bit n = digit n.
- tick_o  output  1  one-cycle pulse on the cycle selec_o advances.

Behaviour:
- Reset (async assert, sync-safe release):
  - prescaler = 0, selec_o = 0, tick_o = 0, anodo_o = 4'b1111.
- Prescaler:
  - Width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1 while en_i = 1, then wraps to 0.
  - Terminal count (REFRESH_DIV-1) with en_i = 1 raises the internal advance strobe.
- tick_o:
  - Registered; high for exactly one cycle, the same cycle selec_o takes its new value.
  - Period REFRESH_DIV cycles while en_i = 1.
  - Pulses even when the next digit equals the current one.
- Digit advance on strobe:
  - next = first index k in order (selec_o+1, +2, +3, +0) mod 4 with digit_en_i[k] = 1.
  - Only the current digit enabled → selec_o unchanged.
  - digit_en_i = 0 → selec_o holds.
  - Wrap 3 → 0 is natural modulo-4 rollover.
- anodo_o:
  - Combinational from registered selec_o and the live inputs.
  - anodo_o = ~(onehot(selec_o) & digit_en_i) when en_i = 1, else 4'b1111.
  - At most one bit low at any time.
- Mask change mid-dwell:
  - Clearing the active digit's bit darkens it immediately.
  - selec_o moves only at the next strobe; no early advance.
- en_i low:
  - Prescaler and selec_o hold; tick_o = 0; anodes all high.
  - On en_i rising, counting resumes from the held prescaler value.
- Reset mid-dwell: all state returns to reset values asynchronously.
  - First strobe after release occurs REFRESH_DIV cycles after the first enabled cycle.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- Defined:
  - anodo_o is forced to 4'b1111 while prescaler < BLANK_CYCLES, i.e. the first BLANK_CYCLES cycles of every dwell, including the first dwell after reset.
  - Prevents ghosting while segment data settles through the mux and decoder.
  - selec_o and tick_o timing unchanged.
- Undefined:
  - No blanking; BLANK_CYCLES is ignored and generates no logic.

Test Plan (REFRESH_DIV = 4, BLANK_CYCLES = 1 where relevant):
- Reset release, en_i = 1, digit_en_i = 4'b1111 → selec_o sequence 0,1,2,3,0, advancing every 4 cycles; tick_o one cycle wide; anodo_o 1110,1101,1011,0111,1110.
- digit_en_i = 4'b1010 from reset → selec_o steps 0→1→3→1→3. During the first dwell (selec_o = 0, bit masked) anodo_o = 1111; then 1101/0111 alternating.
- digit_en_i = 4'b0000 → anodo_o = 1111 constant, selec_o held at 0, tick_o still pulses every 4 cycles.
- Clear the active digit's mask bit mid-dwell at selec_o = 2 → anodo_o goes 1111 the same cycle; selec_o stays 2 until the strobe, then moves to the next enabled index.
- en_i low for 10 cycles at prescaler = 1 → no tick_o, anodo_o = 1111, selec_o frozen. After en_i rises, the next tick_o arrives 3 cycles later.
- GHOST_BLANK_EN defined → anodo_o = 1111 on the first cycle of each dwell and the correct one-hot-low value for the remaining 3; assert rst_n_i mid-dwell → outputs return to reset values without waiting for a clock edge.
